// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - four-way round-robin arbiter feeding a one-word output register
module mux_rr_arbiter #(
   parameter int DATA_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [3:0]            in_valid,
   input  logic [4*DATA_W-1:0]   in_data,
   output logic [3:0]            in_ready,
   output logic                  out_valid,
   output logic [DATA_W-1:0]     out_data,
   output logic [1:0]            out_id,
   input  logic                  out_ready
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [1:0]  ptr;
   logic [1:0]  gnt_idx;
   logic        gnt_any;
   logic        load_slot;
   logic        grant;

   // first active requester in rotating order ptr, ptr+1, ptr+2, ptr+3
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = ptr;
      for (int k = 0; k < 4; k++) begin
         if (!gnt_any && in_valid[ptr + 2'(k)]) begin
            gnt_any = 1'b1;
            gnt_idx = ptr + 2'(k);
         end
      end
   end

   // output register can take a word when empty or being drained this cycle
   assign load_slot = (state == EMPTY) || out_ready;
   assign grant     = load_slot && gnt_any;
   assign out_valid = (state == FULL);

   // one-hot ready; held low while reset is asserted
   always_comb begin
      in_ready = 4'b0000;
      if (grant && rst_n) begin
         in_ready = 4'b0001 << gnt_idx;
      end
   end

   // control state: EMPTY/FULL tracking of the output register
   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: if (grant) state_nxt = FULL;
         FULL:  if (out_ready && !grant) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // output word, its source index and the round-robin pointer advance only on a grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data <= '0;
         out_id   <= 2'd0;
         ptr      <= 2'd0;
      end else if (grant) begin
         out_data <= in_data[gnt_idx*DATA_W +: DATA_W];
         out_id   <= gnt_idx;
         ptr      <= gnt_idx + 2'd1;
      end
   end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter: DATA_W, default 4, width of each requester data word and of the output word.
REQ-002 Ports SHALL be, in order:
 clk  input  1  single clock, all state on rising edge
 rst_n  input  1  asynchronous active-low reset
 in_valid  input  4  bit i: requester i presents a word
 in_data  input  4*DATA_W  requester i word at bits [i*DATA_W +: DATA_W]
 in_ready  output  4  bit i: requester i word accepted this cycle
 out_valid  output  1  output register holds a word
 out_data  output  DATA_W  selected word
 out_id  output  2  index of requester that supplied out_data
 out_ready  input  1  downstream consumes out_data this cycle
REQ-003 The block SHALL have one clock (clk); reset SHALL be asynchronous and active-low (rst_n), and no other clock or reset SHALL exist.

Function
REQ-004 Transfers SHALL occur on a rising clk edge where valid and ready are both 1 on the same channel.
REQ-005 "Load slot" SHALL be true when out_valid is 0, or when out_valid and out_ready are both 1.
REQ-006 When load slot is true and any in_valid bit is 1, exactly one in_ready bit SHALL be 1; otherwise all in_ready bits SHALL be 0.
REQ-007 The granted requester SHALL be the first i with in_valid[i]=1, searching ptr, ptr+1, ptr+2, ptr+3 modulo 4.
REQ-008 in_ready SHALL be combinational from in_valid, ptr, out_valid and out_ready; it SHALL never be 1 for a requester whose in_valid is 0.
REQ-009 On a granted transfer from requester g, the next edge SHALL load out_data with that word, set out_id to g, set out_valid to 1, and set ptr to (g+1) mod 4; g=3 SHALL wrap ptr to 0.
REQ-010 Latency from accepted input to out_valid SHALL be exactly 1 cycle.
REQ-011 With steady in_valid and out_ready held at 1, throughput SHALL be one word per cycle, with no bubble.
REQ-012 When out_valid=1 and out_ready=0 (stall), out_data, out_id, out_valid and ptr SHALL hold, and all in_ready bits SHALL be 0.
REQ-013 If the output drains and a new grant happens in the same cycle, the output register SHALL take the new word and out_valid SHALL stay 1.
REQ-014 If the output drains with no in_valid bit set, out_valid SHALL go to 0 on the next edge; out_data and out_id SHALL hold their last values.
REQ-015 ptr SHALL change only on a granted transfer.
REQ-016 Fairness: a requester holding in_valid=1 SHALL be granted within at most 4 consecutive grants.
REQ-017 The control state SHALL be EMPTY (out_valid=0) or FULL (out_valid=1):
 - EMPTY to FULL on grant.
 - FULL to EMPTY on drain with no grant.
 - FULL stays FULL on stall, or on drain with grant.
REQ-018 out_data SHALL equal the selected in_data slice bit-exactly, including X bits.

Reset
REQ-019 When rst_n=0, the block SHALL immediately, without waiting for clk, force out_valid=0, out_data=0, out_id=0 and ptr=0.
REQ-020 While rst_n=0, in_ready SHALL be 0.
REQ-021 Reset asserted mid-operation SHALL discard any buffered word; after rst_n rises, the first grant SHALL follow REQ-007 with ptr=0.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
 - Reset, then in_valid=4'b1111, data {d,c,b,a} (req3..req0), out_ready=1 -> out_id sequence 0,1,2,3,0 with out_data a,b,c,d,a on consecutive cycles.
 - in_valid=4'b1010, ptr=0 -> grant 1, then 3, then 1 (ptr wraps 3 to 0).
 - FULL with out_data=5, out_ready=0 for 3 cycles, in_valid=4'b1111 -> in_ready=0; out_data=5 and out_id stable; no word lost when out_ready rises.
 - Single requester 2, data 9, out_ready=1, in_valid dropped after 1 cycle -> out_valid=1 for exactly 1 cycle, out_data=9, out_id=2, then out_valid=0.
 - rst_n pulsed low between edges while FULL -> out_valid=0 before the next edge; after release, in_valid=4'b1000 -> first grant is requester 3 and ptr becomes 0.
 - Requester 1 word containing X bits, selected -> out_data reproduces it exactly; the check uses !==.
